// File: rtl/uart_cmd_parser.sv
// Frame decoder for the UART byte stream: HDR0 HDR1 CMD LEN_H LEN_L PAYLOAD CSUM.
// Optional inter-byte timeout is built when UART_CMD_PARSER_TIMEOUT_EN is defined.
module uart_cmd_parser #(
    parameter int         CLK_FREQ      = 50_000_000,
    parameter int         BAUD_RATE     = 115200,
    parameter logic [7:0] HEADER0       = 8'hAA,
    parameter logic [7:0] HEADER1       = 8'h55,
    parameter int         MAX_LEN       = 256,
    parameter int         TIMEOUT_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic [7:0]  cmd_out,
    output logic [15:0] len_out,
    output logic [7:0]  payload_data,
    output logic        payload_valid,
    output logic [15:0] payload_idx,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [1:0]  err_code,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR1, S_CMD, S_LENH, S_LENL, S_PAY, S_CSUM
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    // Reject configurations that would make the timeout limit meaningless.
    if (TIMEOUT_BYTES < 1 || BAUD_RATE < 1 || CLK_FREQ < BAUD_RATE) begin : g_param_check
        $error("uart_cmd_parser: invalid timing parameters");
    end

    state_t      state;
    logic [7:0]  csum;
    logic [7:0]  len_hi;
    logic [15:0] byte_cnt;
    logic [15:0] len_now;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    assign len_now = {len_hi, in_data};
    assign busy    = (state != S_IDLE);

`ifdef UART_CMD_PARSER_TIMEOUT_EN
    localparam logic [1:0]  ERR_TIMEOUT = 2'd3;
    localparam logic [31:0] TO_LIMIT    = 32'(TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE));
    logic [31:0] to_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            csum          <= 8'd0;
            len_hi        <= 8'd0;
            byte_cnt      <= 16'd0;
            cmd_out       <= 8'd0;
            len_out       <= 16'd0;
            payload_data  <= 8'd0;
            payload_valid <= 1'b0;
            payload_idx   <= 16'd0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            err_code      <= ERR_NONE;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
            to_cnt        <= 32'd0;
`endif
        end else begin
            payload_valid <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            err_code      <= ERR_NONE;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
            if (state == S_IDLE || in_valid)
                to_cnt <= 32'd0;
            else if (to_cnt != TO_LIMIT)
                to_cnt <= to_cnt + 32'd1;
`endif
            if (in_valid) begin
                case (state)
                    S_IDLE: begin
                        if (in_data == HEADER0) state <= S_HDR1;
                    end
                    S_HDR1: begin
                        if (in_data == HEADER1)      state <= S_CMD;
                        else if (in_data != HEADER0) state <= S_IDLE;
                    end
                    S_CMD: begin
                        cmd_out <= in_data;
                        csum    <= in_data;
                        state   <= S_LENH;
                    end
                    S_LENH: begin
                        len_hi <= in_data;
                        csum   <= csum_add(csum, in_data);
                        state  <= S_LENL;
                    end
                    S_LENL: begin
                        len_out  <= len_now;
                        csum     <= csum_add(csum, in_data);
                        byte_cnt <= 16'd0;
                        if (len_now > MAX_LEN_W) begin
                            frame_done <= 1'b1;
                            err_code   <= ERR_LEN;
                            state      <= S_IDLE;
                        end else if (len_now == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        payload_data  <= in_data;
                        payload_idx   <= byte_cnt;
                        payload_valid <= 1'b1;
                        csum          <= csum_add(csum, in_data);
                        byte_cnt      <= byte_cnt + 16'd1;
                        if (byte_cnt == len_out - 16'd1) state <= S_CSUM;
                    end
                    S_CSUM: begin
                        frame_done <= 1'b1;
                        frame_ok   <= (in_data == csum);
                        err_code   <= (in_data == csum) ? ERR_NONE : ERR_CSUM;
                        state      <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
`ifdef UART_CMD_PARSER_TIMEOUT_EN
            // A byte arriving on the expiry cycle takes priority over the timeout.
            else if (state != S_IDLE && to_cnt == TO_LIMIT) begin
                frame_done <= 1'b1;
                err_code   <= ERR_TIMEOUT;
                state      <= S_IDLE;
            end
`endif
        end
    end

endmodule
